// File: rtl/coord_divider.sv
// Converts a linear best-match index into frame coordinates: X = FinalIndex / Width, Y = FinalIndex % Width.
// Latency: DATA_W cycles from trigger edge to result edge (same edge for a zero divisor); Done pulses the cycle after.
// Backpressure: none; triggers are sampled only in IDLE, and Start/operand changes during CALC are ignored.
module coord_divider #(
  parameter int   DATA_W     = 32,
  parameter logic AUTO_TRACK = 1'b1
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Start,
  input  logic [DATA_W-1:0] FinalIndex,
  input  logic [DATA_W-1:0] Width,
  output logic [DATA_W-1:0] X,
  output logic [DATA_W-1:0] Y,
  output logic              Busy,
  output logic              Done,
  output logic              DivZero
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  typedef enum logic {
    IDLE = 1'b0,
    CALC = 1'b1
  } stateType;

  stateType state;
  stateType nextState;

  logic [DATA_W-1:0] quoReg;
  logic [DATA_W-1:0] remReg;
  logic [DATA_W-1:0] divisorReg;
  logic [DATA_W-1:0] snapIndex;
  logic [DATA_W-1:0] snapWidth;
  logic [CNT_W-1:0]  iterCnt;

  logic              opsChanged;
  logic              trigger;
  logic              zeroDiv;
  logic              lastIter;
  logic [DATA_W:0]   shifted;
  logic              fits;
  logic [DATA_W-1:0] trialDiff;
  logic [DATA_W-1:0] remNext;
  logic [DATA_W-1:0] quoNext;

  assign opsChanged = ({FinalIndex, Width} != {snapIndex, snapWidth});
  assign trigger    = (state == IDLE) && (Start || (AUTO_TRACK && opsChanged));
  assign zeroDiv    = (Width == '0);
  assign lastIter   = (iterCnt == CNT_W'(1));
  assign Busy       = (state == CALC);

  // One restoring step: shift the next dividend bit into the remainder and
  // subtract the divisor if it fits. Whenever it fits, the true difference is
  // below the divisor, so the low DATA_W bits of the subtraction are exact.
  assign shifted   = {remReg, quoReg[DATA_W-1]};
  assign fits      = (shifted >= {1'b0, divisorReg});
  assign trialDiff = shifted[DATA_W-1:0] - divisorReg;
  assign remNext   = fits ? trialDiff : shifted[DATA_W-1:0];
  assign quoNext   = {quoReg[DATA_W-2:0], fits};

  // State register.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // Next state: a zero divisor completes in IDLE without entering CALC.
  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (trigger && !zeroDiv) nextState = CALC;
      CALC:    if (lastIter) nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // Operand capture, iteration datapath and registered results/flags.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      quoReg     <= '0;
      remReg     <= '0;
      divisorReg <= '0;
      snapIndex  <= '0;
      snapWidth  <= '0;
      iterCnt    <= '0;
      X          <= '0;
      Y          <= '0;
      Done       <= 1'b0;
      DivZero    <= 1'b0;
    end else begin
      Done <= 1'b0;
      if (trigger) begin
        quoReg     <= FinalIndex;
        remReg     <= '0;
        divisorReg <= Width;
        snapIndex  <= FinalIndex;
        snapWidth  <= Width;
        iterCnt    <= CNT_W'(DATA_W);
        if (zeroDiv) begin
          X       <= '1;
          Y       <= FinalIndex;
          DivZero <= 1'b1;
          Done    <= 1'b1;
        end
      end else if (state == CALC) begin
        quoReg  <= quoNext;
        remReg  <= remNext;
        iterCnt <= iterCnt - CNT_W'(1);
        if (lastIter) begin
          X       <= quoNext;
          Y       <= remNext;
          DivZero <= 1'b0;
          Done    <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_coord_divider.sv
// Directed bench for coord_divider: one instance without auto-tracking, one with.
// Table-driven Start runs plus hand-written mid-CALC, reset-abort and auto-track sequences.
module tb_coord_divider;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        start0, start1;
  logic [31:0] idx0, wid0, idx1, wid1;
  logic [31:0] x0, y0, x1, y1;
  logic        busy0, done0, dz0, busy1, done1, dz1;

  always #5 Clk = ~Clk;

  coord_divider #(.DATA_W(32), .AUTO_TRACK(1'b0)) dut0 (
    .Clk(Clk), .Reset(Reset), .Start(start0), .FinalIndex(idx0), .Width(wid0),
    .X(x0), .Y(y0), .Busy(busy0), .Done(done0), .DivZero(dz0)
  );

  coord_divider #(.DATA_W(32), .AUTO_TRACK(1'b1)) dut1 (
    .Clk(Clk), .Reset(Reset), .Start(start1), .FinalIndex(idx1), .Width(wid1),
    .X(x1), .Y(y1), .Busy(busy1), .Done(done1), .DivZero(dz1)
  );

  typedef struct {
    logic [31:0] idx;
    logic [31:0] wid;
    logic [31:0] expX;
    logic [31:0] expY;
    logic        expDz;
  } vecT;

  int nCompared   = 0;
  int nMismatched = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge Clk);
    #1;
  endtask

  // Pulse Start on dut0, then wait (bounded) for Done; report latency and Busy cycles.
  task automatic runStart0(input logic [31:0] a, input logic [31:0] b,
                           output int lat, output int busyCyc);
    idx0   = a;
    wid0   = b;
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    lat     = 0;
    busyCyc = 0;
    while (!done0 && lat < 60) begin
      if (busy0) busyCyc++;
      tick();
      lat++;
    end
  endtask

  // Observe dut1 for a number of cycles, recording Done pulses and the results they tag.
  task automatic watch1(input int cycles, output int nd,
                        output logic [31:0] fx, output logic [31:0] fy,
                        output logic [31:0] lx, output logic [31:0] ly,
                        output int firstAt);
    nd = 0; fx = '0; fy = '0; lx = '0; ly = '0; firstAt = -1;
    for (int i = 1; i <= cycles; i++) begin
      tick();
      if (done1) begin
        if (nd == 0) begin
          fx = x1; fy = y1; firstAt = i;
        end
        lx = x1; ly = y1;
        nd++;
      end
    end
  endtask

  vecT         vecs[8];
  int          lat, busyCyc, nd, nb, firstAt;
  logic [31:0] fx, fy, lx, ly;

  initial begin
    vecs[0] = '{32'd1000,       32'd64,         32'd15,         32'd40, 1'b0};
    vecs[1] = '{32'd77,         32'd0,          32'hFFFF_FFFF,  32'd77, 1'b1};
    vecs[2] = '{32'd10,         32'd3,          32'd3,          32'd1,  1'b0};
    vecs[3] = '{32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0,  1'b0};
    vecs[4] = '{32'd5,          32'd7,          32'd0,          32'd5,  1'b0};
    vecs[5] = '{32'd0,          32'd9,          32'd0,          32'd0,  1'b0};
    vecs[6] = '{32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd1,          32'd0,  1'b0};
    vecs[7] = '{32'd123456,     32'd640,        32'd192,        32'd576, 1'b0};

    Reset  = 1'b0;
    start0 = 1'b0; idx0 = '0; wid0 = '0;
    start1 = 1'b0; idx1 = '0; wid1 = '0;
    repeat (3) tick();

    check("rst0.X", x0, 0);        check("rst0.Y", y0, 0);
    check("rst0.Busy", busy0, 0);  check("rst0.Done", done0, 0);
    check("rst0.DivZero", dz0, 0);
    check("rst1.X", x1, 0);        check("rst1.Y", y1, 0);
    check("rst1.Busy", busy1, 0);  check("rst1.Done", done1, 0);
    check("rst1.DivZero", dz1, 0);

    Reset = 1'b1;
    repeat (2) tick();
    // Zero operands match the reset snapshot, so auto-tracking must stay idle.
    check("idle1.Busy", busy1, 0);

    // Table of Start-triggered runs on the non-tracking instance.
    for (int i = 0; i < 8; i++) begin
      runStart0(vecs[i].idx, vecs[i].wid, lat, busyCyc);
      check($sformatf("v%0d.DoneSeen", i), done0, 1);
      check($sformatf("v%0d.Latency", i), lat, (vecs[i].wid == 0) ? 0 : 32);
      check($sformatf("v%0d.BusyCycles", i), busyCyc, (vecs[i].wid == 0) ? 0 : 32);
      check($sformatf("v%0d.X", i), x0, vecs[i].expX);
      check($sformatf("v%0d.Y", i), y0, vecs[i].expY);
      check($sformatf("v%0d.DivZero", i), dz0, vecs[i].expDz);
      tick();
      check($sformatf("v%0d.DoneOneCycle", i), done0, 0);
      tick();
    end

    // Start pulse and operand change mid-CALC are ignored.
    idx0 = 1000; wid0 = 64; start0 = 1'b1;
    tick();
    start0 = 1'b0;
    repeat (4) tick();
    idx0 = 9; wid0 = 2; start0 = 1'b1;
    tick();
    start0 = 1'b0;
    lat = 5;
    while (!done0 && lat < 60) begin
      tick();
      lat++;
    end
    check("mid0.DoneSeen", done0, 1);
    check("mid0.Latency", lat, 32);
    check("mid0.X", x0, 15);
    check("mid0.Y", y0, 40);
    nd = 0; nb = 0;
    repeat (40) begin
      tick();
      if (done0) nd++;
      if (busy0) nb++;
    end
    check("mid0.NoSecondDone", nd, 0);
    check("mid0.NoSecondBusy", nb, 0);

    // Reset asserted mid-CALC aborts immediately and asynchronously.
    idx0 = 1000; wid0 = 64; start0 = 1'b1;
    tick();
    start0 = 1'b0;
    repeat (9) tick();
    check("abort.BusyBefore", busy0, 1);
    check("abort.XBefore", x0, 15);
    #3 Reset = 1'b0;
    #1;
    check("abort.X", x0, 0);
    check("abort.Y", y0, 0);
    check("abort.Busy", busy0, 0);
    check("abort.Done", done0, 0);
    @(posedge Clk);
    #1 Reset = 1'b1;
    runStart0(32'd100, 32'd10, lat, busyCyc);
    check("post.DoneSeen", done0, 1);
    check("post.Latency", lat, 32);
    check("post.X", x0, 10);
    check("post.Y", y0, 0);

    // Auto-track: nonzero operands at reset release trigger one run on the first edge.
    Reset = 1'b0;
    idx1 = 1000; wid1 = 64;
    repeat (2) tick();
    Reset = 1'b1;
    watch1(80, nd, fx, fy, lx, ly, firstAt);
    check("at.Dones", nd, 1);
    check("at.FirstAt", firstAt, 33);
    check("at.X", fx, 15);
    check("at.Y", fy, 40);

    idx1 = 1001;
    watch1(80, nd, fx, fy, lx, ly, firstAt);
    check("at1001.Dones", nd, 1);
    check("at1001.X", fx, 15);
    check("at1001.Y", fy, 41);

    // Operand change mid-CALC under auto-track: first result unaffected, then a rerun.
    idx1 = 1000;
    repeat (5) tick();
    idx1 = 9; wid1 = 2;
    watch1(100, nd, fx, fy, lx, ly, firstAt);
    check("atmid.Dones", nd, 2);
    check("atmid.X1", fx, 15);
    check("atmid.Y1", fy, 40);
    check("atmid.X2", lx, 4);
    check("atmid.Y2", ly, 1);
    check("atmid.DivZero", dz1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $fatal(1);
  end

endmodule
